mem_line_arbiter: RTL
=====================

Name: mem_line_arbiter

Overview:
- Sits between the cache-side requesters and main_memory in the MSI bus system.
- Arbitrates two requesters round-robin: port 0 is the line-fill (read) path, port 1 is the writeback path. Either port may issue reads or writes.
- Sequences each granted request as a BURST-word cache-line transfer, driving main_memory's rd_mem/wr_mem/addr_mem/data_in.
- Returns read data with fixed timing; main_memory's ready_mem is not used as a handshake.

Parameters:
- AWIDTH, 9, word address width; must match main_memory.
- DWIDTH, 32, data word width; must match main_memory.
- BURST, 4, words per cache line; power of two, 1..2^AWIDTH.

Ports:
- clk  in  1  clock, rising-edge logic; main_memory samples on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request pending.
- req0_we  in  1  1 = line write, 0 = line read.
- req0_addr  in  AWIDTH  line address; the low log2(BURST) bits are ignored.
- req0_wdata  in  DWIDTH  current write word.
- req0_wack  out  1  write word consumed; the requester advances req0_wdata next cycle.
- req0_rdata  out  DWIDTH  read word.
- req0_rvalid  out  1  req0_rdata valid this cycle.
- req0_done  out  1  one-cycle pulse when the transfer completes.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_wack, req1_rdata, req1_rvalid, req1_done: same as port 0, for port 1.
- rd_mem  out  1  to main_memory.
- wr_mem  out  1  to main_memory.
- addr_mem  out  AWIDTH  to main_memory.
- mem_wdata  out  DWIDTH  to main_memory data_in.
- mem_rdata  in  DWIDTH  from main_memory data_out.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, last_grant=1 (so port 0 wins first).
  - Beat counter 0.
  - All outputs 0, including rd_mem/wr_mem, which drop immediately.
  - A reset mid-burst aborts the burst: words already written stay in memory, and no done is issued.
- State machine:
  - IDLE: if any valid is high, pick the winner, latch its addr/we/id, go to XFER. Beat=0.
  - XFER: one memory beat per cycle, beats 0..BURST-1.
    - addr_mem = {line_addr[AWIDTH-1:log2(BURST)], beat}. The beat field wraps within the line; no carry into the line address.
    - Write: wr_mem=1, mem_wdata = winner's wdata (combinational pass-through), wack=1 to the winner. Memory captures at the falling edge of the same cycle.
    - Read: rd_mem=1. Memory registers the address at the falling edge; mem_rdata is sampled at the next rising edge into the rdata register. rvalid is asserted the following cycle, i.e. 1-cycle latency per beat.
    - After beat BURST-1, go to FIN.
  - FIN (1 cycle): rd_mem=wr_mem=0.
    - done=1 to the winner. For reads, this coincides with the last rvalid.
    - last_grant=winner. Go to IDLE.
- Arbitration:
  - Sampled only in IDLE.
  - If both ports are valid, the port not equal to last_grant wins.
  - A single valid port wins regardless of last_grant.
- Requester contract:
  - valid may stay high through done. The controller ignores it outside IDLE.
  - Still high in the cycle after FIN means a new request.
  - Back-to-back minimum period: BURST+2 cycles per line.
- Output routing: rvalid/wack/done go only to the winner; the loser sees 0. rdata is shared data, qualified by the per-port rvalid.
- rd_mem and wr_mem are never both 1. Both are 0 in IDLE and FIN.
- busy=1 in XFER and FIN.

Test Plan:
- Reset, then req0 read at addr 0x013 (BURST=4), memory preloaded with words[0x010..0x013]=A,B,C,D:
  - addr_mem=0x010..0x013 on 4 consecutive cycles.
  - req0_rvalid high 4 cycles with rdata A,B,C,D.
  - req0_done with D. busy deasserts after.
- req1 write to line 0x1FC with data 1,2,3,4:
  - wr_mem high 4 cycles, addr 0x1FC..0x1FF, req1_wack 4 pulses.
  - Reading 0x1FC..0x1FF back via port 0 yields 1,2,3,4.
  - No wrap into 0x000.
- Both valid in the same cycle after reset: port 0 served first.
  - Both held high: grants alternate 0,1,0,1 over 4 lines.
  - Each line takes 6 cycles from grant to done.
- Only req1 valid with last_grant=1: port 1 granted again; port 0 outputs stay 0.
- Assert reset at beat 2 of a port 1 write of 5,6,7,8 to 0x020:
  - wr_mem drops asynchronously; no done.
  - Memory 0x020=5, 0x021=6; 0x022/0x023 unchanged.
  - After release, state=IDLE and port 0 wins the next contention.
- Read immediately following write to the same line: the read returns the newly written data, with no stale word on beat 0.

Source files
------------

// File: rtl/mem_line_arbiter.sv
// Two-port round-robin arbiter that turns each granted request into a
// BURST-word cache-line transfer against main_memory (falling-edge memory).
module mem_line_arbiter #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    output logic              req0_wack,
    output logic [DWIDTH-1:0] req0_rdata,
    output logic              req0_rvalid,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              req1_wack,
    output logic [DWIDTH-1:0] req1_rdata,
    output logic              req1_rvalid,
    output logic              req1_done,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [AWIDTH-1:0] addr_mem,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy
);
    localparam int                BW        = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [AWIDTH-1:0] BEAT_MASK = AWIDTH'(BURST - 1);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic                r_id;
    logic                r_we;
    logic [BW-1:0]       r_beat;
    logic [AWIDTH-1:0]   r_line;
    logic                r_rvalid;
    logic [DWIDTH-1:0]   r_rdata;
    logic                w_any;
    logic                w_win;

    assign w_any = req0_valid | req1_valid;
    // On contention the port that did not win last time is served.
    assign w_win = (req0_valid & req1_valid) ? ~r_last : req1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        addr_mem    = '0;
        mem_wdata   = '0;
        req0_wack   = 1'b0;
        req1_wack   = 1'b0;
        req0_done   = 1'b0;
        req1_done   = 1'b0;
        busy        = (r_state != S_IDLE);
        req0_rvalid = r_rvalid & ~r_id;
        req1_rvalid = r_rvalid &  r_id;
        req0_rdata  = r_rdata;
        req1_rdata  = r_rdata;
        case (r_state)
            S_IDLE: if (w_any) w_next = S_XFER;
            S_XFER: begin
                if (r_beat == LAST_BEAT) w_next = S_FIN;
                // Beat field wraps inside the line; never carries into the line address.
                addr_mem = (r_line & ~BEAT_MASK) | (AWIDTH'(r_beat) & BEAT_MASK);
                if (r_we) begin
                    wr_mem    = 1'b1;
                    mem_wdata = r_id ? req1_wdata : req0_wdata;
                    req0_wack = ~r_id;
                    req1_wack =  r_id;
                end else begin
                    rd_mem = 1'b1;
                end
            end
            S_FIN: begin
                w_next    = S_IDLE;
                req0_done = ~r_id;
                req1_done =  r_id;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_beat   <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            // Memory presents read data after the falling edge of the read beat.
            r_rvalid <= rd_mem;
            if (rd_mem) r_rdata <= mem_rdata;
            case (r_state)
                S_IDLE: begin
                    r_beat <= '0;
                    if (w_any) begin
                        r_id <= w_win;
                        r_we <= w_win ? req1_we : req0_we;
                    end
                end
                S_XFER:  r_beat <= r_beat + BW'(1);
                S_FIN:   r_last <= r_id;
                default: r_beat <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_any) r_line <= w_win ? req1_addr : req0_addr;
    end
endmodule
